// File: rtl/sdio_spi_pkg.sv
// Shared definitions for the SDIO capture / SPI readout path: sequencer
// states, SPI command opcodes and the default underrun fill byte.
package sdio_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LEN       = 3'd1,
        ST_FETCH     = 3'd2,
        ST_CAPT      = 3'd3,
        ST_SEND      = 3'd4,
        ST_FLUSH_RD  = 3'd5,
        ST_FLUSH_CHK = 3'd6
    } sched_state_t;

    localparam logic [7:0] CMD_BURST    = 8'hCC;
    localparam logic [7:0] CMD_WR_CTRL  = 8'h02;
    localparam logic [7:0] CMD_RD_CTRL  = 8'h03;
    localparam logic [7:0] CMD_RD_LVL   = 8'h05;
    localparam logic [7:0] FILL_DEFAULT = 8'hFF;

endpackage

// File: rtl/sdio_burst_sched.sv
// Burst readout sequencer: owns the capture FIFO read port and feeds one
// FIFO entry (or the fill byte on underrun) into the SPI transmit register
// per SPI byte slot. Also drains the FIFO on a control-register flush.
//
// Handshakes: cmd_vld, tx_done and flush_req are single-cycle event pulses
// with no back-pressure. fifo_rd is a one-cycle pop strobe; fifo_dat shows
// the FIFO head and is sampled in the cycle fifo_rd is high. tx_load is a
// one-cycle strobe marking a new tx_dat. All outputs come from registers.
module sdio_burst_sched
    import sdio_spi_pkg::*;
#(
    parameter int              DW   = 8,
    parameter int              LW   = 6,
    parameter logic [DW-1:0]   FILL = DW'(FILL_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_vld,
    input  logic [DW-1:0]      cmd_dat,
    input  logic               tx_done,
    input  logic               cs_idle,
    input  logic               flush_req,
    input  logic               fifo_empty,
    input  logic [DW-1:0]      fifo_dat,
    output logic               fifo_rd,
    output logic [DW-1:0]      tx_dat,
    output logic               tx_load,
    output logic               busy,
    output logic [8:0]         rem_cnt,
    output logic [7:0]         urun_cnt,
    output sched_state_t       state_dbg,
    output logic [LW-1:0]      flush_cnt
);

    sched_state_t state;
    logic         flush_pend;
    logic         is_burst_cmd;
    logic [8:0]   len_val;

    // Length byte 0 encodes a full 256-byte burst.
    assign len_val      = (cmd_dat[7:0] == 8'h00) ? 9'd256 : {1'b0, cmd_dat[7:0]};
    assign is_burst_cmd = cmd_vld && (cmd_dat == DW'(CMD_BURST));
    assign state_dbg    = state;

    // Sequencer: state, strobes, transmit data and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            fifo_rd    <= 1'b0;
            tx_load    <= 1'b0;
            tx_dat     <= '0;
            rem_cnt    <= '0;
            urun_cnt   <= '0;
            busy       <= 1'b0;
            flush_pend <= 1'b0;
            flush_cnt  <= '0;
        end else begin
            fifo_rd <= 1'b0;
            tx_load <= 1'b0;
            if (flush_req) begin
                flush_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    // A new burst command beats a pending flush.
                    if (is_burst_cmd) begin
                        state <= ST_LEN;
                        busy  <= 1'b1;
                    end else if (flush_pend) begin
                        state     <= ST_FLUSH_RD;
                        busy      <= 1'b1;
                        flush_cnt <= '0;
                    end
                end

                ST_LEN: begin
                    if (cs_idle) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        rem_cnt <= '0;
                    end else if (cmd_vld) begin
                        // The first slot is fetched straight from here so the
                        // first byte is ready as early as possible.
                        if (!fifo_empty) begin
                            fifo_rd <= 1'b1;
                            rem_cnt <= len_val;
                            state   <= ST_CAPT;
                        end else begin
                            tx_dat   <= FILL;
                            tx_load  <= 1'b1;
                            urun_cnt <= (urun_cnt == 8'hFF) ? urun_cnt : urun_cnt + 8'd1;
                            rem_cnt  <= len_val - 9'd1;
                            state    <= ST_SEND;
                        end
                    end
                end

                ST_FETCH: begin
                    if (cs_idle) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        rem_cnt <= '0;
                    end else if (!fifo_empty) begin
                        fifo_rd <= 1'b1;
                        state   <= ST_CAPT;
                    end else begin
                        tx_dat   <= FILL;
                        tx_load  <= 1'b1;
                        urun_cnt <= (urun_cnt == 8'hFF) ? urun_cnt : urun_cnt + 8'd1;
                        rem_cnt  <= rem_cnt - 9'd1;
                        state    <= ST_SEND;
                    end
                end

                ST_CAPT: begin
                    // On abort the entry just popped is dropped.
                    if (cs_idle) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        rem_cnt <= '0;
                    end else begin
                        tx_dat  <= fifo_dat;
                        tx_load <= 1'b1;
                        rem_cnt <= rem_cnt - 9'd1;
                        state   <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    // Host dummy bytes arriving on cmd_vld are ignored here.
                    if (cs_idle) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        rem_cnt <= '0;
                    end else if (tx_done) begin
                        if (rem_cnt == 9'd0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end

                ST_FLUSH_RD: begin
                    if (fifo_empty) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        flush_pend <= flush_req;
                    end else begin
                        fifo_rd   <= 1'b1;
                        flush_cnt <= flush_cnt + 1'b1;
                        state     <= ST_FLUSH_CHK;
                    end
                end

                ST_FLUSH_CHK: begin
                    // Gap cycle: fifo_empty catches up with the pop.
                    state <= ST_FLUSH_RD;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdio_burst_sched.sv
// Bench for sdio_burst_sched: a queue-based FIFO model, directed scenarios
// from the test plan plus randomized bursts, scored against an expected
// byte queue and simple per-burst arithmetic.
module tb_sdio_burst_sched;
    import sdio_spi_pkg::*;

    localparam int         DW     = 8;
    localparam int         LW     = 6;
    localparam logic [7:0] FILL_B = 8'hFF;

    // ---------------- clock / reset / signals ----------------
    logic               clk        = 1'b0;
    logic               rst        = 1'b1;
    logic               cmd_vld    = 1'b0;
    logic [DW-1:0]      cmd_dat    = '0;
    logic               tx_done    = 1'b0;
    logic               cs_idle    = 1'b0;
    logic               flush_req  = 1'b0;
    logic               fifo_empty = 1'b1;
    logic [DW-1:0]      fifo_dat   = '0;
    logic               fifo_rd;
    logic [DW-1:0]      tx_dat;
    logic               tx_load;
    logic               busy;
    logic [8:0]         rem_cnt;
    logic [7:0]         urun_cnt;
    sched_state_t       state_dbg;
    logic [LW-1:0]      flush_cnt;

    always #5 clk = ~clk;

    sdio_burst_sched #(.DW(DW), .LW(LW), .FILL(FILL_B)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_vld    (cmd_vld),
        .cmd_dat    (cmd_dat),
        .tx_done    (tx_done),
        .cs_idle    (cs_idle),
        .flush_req  (flush_req),
        .fifo_empty (fifo_empty),
        .fifo_dat   (fifo_dat),
        .fifo_rd    (fifo_rd),
        .tx_dat     (tx_dat),
        .tx_load    (tx_load),
        .busy       (busy),
        .rem_cnt    (rem_cnt),
        .urun_cnt   (urun_cnt),
        .state_dbg  (state_dbg),
        .flush_cnt  (flush_cnt)
    );

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            rd_log[$];
    int            cyc = 0;
    int            rd_cnt = 0;
    int            load_cnt = 0;
    int            last_load_cyc = 0;
    int            busy_cyc = 0;
    int            viol = 0;
    int            overread = 0;
    int            extra_loads = 0;
    int            exp_urun = 0;
    logic          prev_rd = 1'b0;
    logic          prev_load = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    // FIFO model (show-ahead head, pop on fifo_rd) and output monitor.
    always @(posedge clk) begin
        if (fifo_rd) begin
            rd_cnt++;
            rd_log.push_back(cyc);
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            else overread++;
        end
        if (tx_load) begin
            load_cnt++;
            last_load_cyc = cyc;
            if (exp_q.size() == 0) extra_loads++;
            else check("tx_dat", tx_dat, exp_q.pop_front());
        end
        if (fifo_rd && prev_rd) viol++;
        if (tx_load && prev_load) viol++;
        prev_rd   = fifo_rd;
        prev_load = tx_load;
        if (busy) busy_cyc++;
        fifo_empty <= (fifo_q.size() == 0);
        fifo_dat   <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
        cyc++;
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send_byte(input logic [7:0] b, output int t);
        cmd_vld = 1'b1;
        cmd_dat = b;
        t = cyc;
        @(negedge clk);
        cmd_vld = 1'b0;
        cmd_dat = '0;
    endtask

    task automatic pulse_done(output int t);
        tx_done = 1'b1;
        t = cyc;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    task automatic wait_load(input int prev);
        for (int k = 0; k < 12 && load_cnt == prev; k++) @(negedge clk);
        check("load_seen", (load_cnt != prev), 1);
    endtask

    task automatic wait_idle(input int lim);
        for (int k = 0; k < lim && busy; k++) @(negedge clk);
        check("idle_reached", busy, 0);
    endtask

    // One burst of L bytes. abort_at: raise cs_idle after that tx_done.
    // flush_at: pulse flush_req after that load. late_push: entries added
    // after the last load, before the final tx_done.
    task automatic run_burst(input int L, input int abort_at, input int flush_at, input int late_push);
        int n, nl, nr, t, u, prev, rd0, rd_b;
        n  = fifo_q.size();
        nl = (abort_at > 0) ? abort_at : L;
        nr = (nl < n) ? nl : n;
        for (int i = 0; i < nl; i++) exp_q.push_back((i < n) ? fifo_q[i] : FILL_B);
        exp_urun = exp_urun + (nl - nr);
        if (exp_urun > 255) exp_urun = 255;
        rd0 = rd_cnt;
        rd_b = 0;
        u = 0;
        send_byte(CMD_BURST, t);
        prev = load_cnt;
        send_byte(8'(L), t);
        for (int i = 1; i <= nl; i++) begin
            wait_load(prev);
            if (i == 1) begin
                check("lat_len", last_load_cyc - t, (n > 0) ? 2 : 1);
                check("busy_in_burst", busy, 1);
            end else begin
                check("lat_done", last_load_cyc - u, (i <= n) ? 3 : 2);
            end
            check("rem_cnt", rem_cnt, L - i);
            if (i == nl) rd_b = rd_cnt - rd0;
            if (i == flush_at) pulse_flush();
            if (i == L) begin
                for (int k = 0; k < late_push; k++) fifo_q.push_back(8'(8'h50 + k));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            prev = load_cnt;
            pulse_done(u);
            if (i == abort_at) begin
                cs_idle = 1'b1;
                @(negedge clk);
                check("abort_idle", busy, 0);
                check("abort_rem", rem_cnt, 0);
                check("abort_state", state_dbg, ST_IDLE);
                @(negedge clk);
                cs_idle = 1'b0;
                repeat (3) @(negedge clk);
                check("abort_no_read", rd_cnt - rd0, nr);
                break;
            end
        end
        wait_idle(8);
        check("burst_reads", rd_b, nr);
        check("urun_cnt", urun_cnt, exp_urun);
    endtask

    task automatic do_flush(input int n);
        int b0, r0;
        b0 = busy_cyc;
        r0 = rd_cnt;
        rd_log.delete();
        pulse_flush();
        for (int k = 0; k < 6 && !busy; k++) @(negedge clk);
        check("flush_start", busy, 1);
        wait_idle(2 * n + 10);
        check("flush_busy_cycles", busy_cyc - b0, 2 * n + 1);
        check("flush_reads", rd_cnt - r0, n);
        for (int i = 1; i < rd_log.size(); i++) check("flush_gap", rd_log[i] - rd_log[i-1], 2);
        check("flush_cnt", flush_cnt, n);
        check("fifo_drained", fifo_q.size(), 0);
        check("fifo_empty", fifo_empty, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fifo_rd"}, fifo_rd, 0);
        check({tag, "_tx_load"}, tx_load, 0);
        check({tag, "_tx_dat"}, tx_dat, 0);
        check({tag, "_rem_cnt"}, rem_cnt, 0);
        check({tag, "_urun_cnt"}, urun_cnt, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_state"}, state_dbg, ST_IDLE);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t, n, L;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Ignored non-burst byte in IDLE.
        send_byte(8'h05, t);
        check("ignore_byte", busy, 0);

        // Three entries, three bytes.
        fifo_q.push_back(8'hA1); fifo_q.push_back(8'hA2); fifo_q.push_back(8'hA3);
        @(negedge clk);
        run_burst(3, 0, 0, 0);
        check("end_state", state_dbg, ST_IDLE);

        // One entry, two bytes: second byte is fill.
        fifo_q.push_back(8'hB1);
        @(negedge clk);
        run_burst(2, 0, 0, 0);

        // Length 0 = 256 bytes from a 300-entry FIFO; then drain the rest.
        for (int k = 0; k < 300; k++) fifo_q.push_back(8'($urandom));
        @(negedge clk);
        run_burst(256, 0, 0, 0);
        check("left_after_256", fifo_q.size(), 44);
        do_flush(44);

        // Abort after second tx_done, then flush the remaining five.
        for (int k = 0; k < 7; k++) fifo_q.push_back(8'(8'h70 + k));
        @(negedge clk);
        run_burst(4, 2, 0, 0);
        check("left_after_abort", fifo_q.size(), 5);
        do_flush(5);

        // Flush requested mid-burst; underruns drive the counter past 255.
        fifo_q.push_back(8'hC1);
        @(negedge clk);
        run_burst(256, 0, 3, 4);
        repeat (3) @(negedge clk);
        wait_idle(40);
        check("deferred_flush_cnt", flush_cnt, 4);
        check("deferred_flush_drained", fifo_q.size(), 0);
        check("urun_saturated", urun_cnt, 255);

        // Reset in the middle of a burst.
        for (int k = 0; k < 10; k++) fifo_q.push_back(8'(8'h60 + k));
        @(negedge clk);
        exp_q.push_back(fifo_q[0]);
        send_byte(CMD_BURST, t);
        L = load_cnt;
        send_byte(8'd5, t);
        wait_load(L);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        check("midrst_flush_cnt", flush_cnt, 0);
        rst = 1'b0;
        exp_urun = 0;
        exp_q.delete();
        fifo_q.delete();
        @(negedge clk);

        // Randomized bursts against the queue model.
        for (int it = 0; it < 10; it++) begin
            b = 8'($urandom_range(0, 200));
            send_byte(b, t);
            check("rand_ignore", busy, 0);
            n = $urandom_range(0, 10);
            L = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) fifo_q.push_back(8'($urandom));
            @(negedge clk);
            run_burst(L, 0, 0, 0);
            fifo_q.delete();
            @(negedge clk);
        end

        // Global properties.
        check("no_back_to_back_strobes", viol, 0);
        check("no_over_read", overread, 0);
        check("no_unexpected_loads", extra_loads, 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
